rcc_rst_seq: RTL and testbench

RCC_RST_SEQ -- requirements
Module: rcc_rst_seq

---
 rtl/rcc_pkg.sv | 60 ++++++
 rtl/rst_glitch_filter.sv | 29 ++
 rtl/rcc_rst_seq.sv | 135 +++++++++++++
 tb/tb_rcc_rst_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rcc_pkg.sv
// Shared definitions for the reset/clock-control release sequencer:
// state encodings, rst_cause bit positions, default timing and output decode.
package rcc_pkg;

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_REL_SYS   = 3'd2,
        S_REL_APB   = 3'd3,
        S_RUN       = 3'd4,
        S_SW_HOLD   = 3'd5
    } seq_state_e;

    localparam int CAUSE_EXT  = 0;
    localparam int CAUSE_LOCK = 1;
    localparam int CAUSE_SW   = 2;
    localparam int CAUSE_W    = 3;

    localparam int LOCK_STABLE_DEF = 64;
    localparam int STAGE_GAP_DEF   = 16;
    localparam int FILTER_LEN_DEF  = 8;

    localparam int NUM_APB = 3;

    typedef struct packed {
        logic               sys;
        logic [NUM_APB-1:0] apb;
        logic               eth;
    } rstn_t;

    // Domain resets released per state; anything not listed stays in reset.
    function automatic rstn_t rstn_dec(input seq_state_e s);
        rstn_t r;
        r = '0;
        case (s)
            S_REL_SYS: r.sys = 1'b1;
            S_REL_APB: begin
                r.sys = 1'b1;
                r.apb = '1;
            end
            S_RUN: begin
                r.sys = 1'b1;
                r.apb = '1;
                r.eth = 1'b1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // One counter width shared by every counter, sized off the longest timer.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rst_glitch_filter.sv
// Debounce for the synchronised pin reset: output follows the input only after
// the input has held a new value for FILTER_LEN consecutive cycles.
module rst_glitch_filter #(
    parameter int FILTER_LEN = 8,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 1'b0;
            cnt  <= '0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rcc_rst_seq.sv
// Staged reset release sequencer: sys -> apb -> eth after PLL lock, with
// lock-loss and software restart. Define RST_FILTER_EN to debounce ext_rstn.
import rcc_pkg::*;

module rcc_rst_seq #(
    parameter int LOCK_STABLE = LOCK_STABLE_DEF,
    parameter int STAGE_GAP   = STAGE_GAP_DEF,
    parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
    input  logic               sys_root_clk,
    input  logic               sys_root_rst,
    input  logic               ext_rstn,
    input  logic               pll_locked,
    input  logic               sw_rst_req,
    input  logic               cause_clr,
    output logic               sys_rstn_o,
    output logic [NUM_APB-1:0] apb_rstn_o,
    output logic               eth_rstn_o,
    output logic               sw_rst_ack,
    output logic [CAUSE_W-1:0] rst_cause,
    output logic [2:0]         seq_state
);

    localparam int CNT_W = cnt_width(LOCK_STABLE, STAGE_GAP, FILTER_LEN);
    localparam logic [CAUSE_W-1:0] CAUSE_RST = CAUSE_W'(1) << CAUSE_EXT;

    logic               ext_f;
    seq_state_e         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               ext_evt, lock_evt, sw_evt;
    logic [CAUSE_W-1:0] cause_set;
    rstn_t              rstn_q;

`ifdef RST_FILTER_EN
    rst_glitch_filter #(
        .FILTER_LEN (FILTER_LEN),
        .CNT_W      (CNT_W)
    ) u_filt (
        .clk  (sys_root_clk),
        .rst  (sys_root_rst),
        .din  (ext_rstn),
        .dout (ext_f)
    );
`else
    always_ff @(posedge sys_root_clk) begin
        if (sys_root_rst) ext_f <= 1'b0;
        else              ext_f <= ext_rstn;
    end
`endif

    // Restart events, highest priority first: pin reset, lock loss, software.
    always_comb begin
        ext_evt  = !ext_f;
        lock_evt = !ext_evt && !pll_locked &&
                   (state inside {S_REL_SYS, S_REL_APB, S_RUN, S_SW_HOLD});
        sw_evt   = !ext_evt && !lock_evt && sw_rst_req && (state == S_RUN);

        cause_set             = '0;
        cause_set[CAUSE_EXT]  = ext_evt;
        cause_set[CAUSE_LOCK] = lock_evt;
        cause_set[CAUSE_SW]   = sw_evt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (ext_evt) begin
            state_nxt = S_HOLD;
            cnt_nxt   = '0;
        end else if (lock_evt) begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = '0;
        end else if (sw_evt) begin
            state_nxt = S_SW_HOLD;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_HOLD: begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
                S_WAIT_LOCK: begin
                    if (!pll_locked) begin
                        cnt_nxt = '0;
                    end else if (cnt == CNT_W'(LOCK_STABLE - 1)) begin
                        state_nxt = S_REL_SYS;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_REL_SYS, S_REL_APB, S_SW_HOLD: begin
                    if (cnt == CNT_W'(STAGE_GAP - 1)) begin
                        cnt_nxt = '0;
                        case (state)
                            S_REL_SYS: state_nxt = S_REL_APB;
                            S_REL_APB: state_nxt = S_RUN;
                            default:   state_nxt = S_REL_SYS;
                        endcase
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_RUN: cnt_nxt = '0;
                default: begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they flip on the same edge.
    always_ff @(posedge sys_root_clk) begin
        if (sys_root_rst) begin
            state      <= S_HOLD;
            cnt        <= '0;
            rstn_q     <= '0;
            sw_rst_ack <= 1'b0;
            rst_cause  <= CAUSE_RST;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rstn_q     <= rstn_dec(state_nxt);
            sw_rst_ack <= sw_evt;
            rst_cause  <= (cause_clr ? '0 : rst_cause) | cause_set;
        end
    end

    assign sys_rstn_o = rstn_q.sys;
    assign apb_rstn_o = rstn_q.apb;
    assign eth_rstn_o = rstn_q.eth;
    assign seq_state  = state;

endmodule

// File: tb/tb_rcc_rst_seq.sv
// Bench for rcc_rst_seq: directed release/restart scenarios plus a random
// phase, all cross-checked against a cycle-level behavioural model.
module tb_rcc_rst_seq;

    localparam int LS = 64;
    localparam int SG = 16;
    localparam int FL = 8;
`ifdef RST_FILTER_EN
    localparam int FILT_LAT = FL;
`else
    localparam int FILT_LAT = 1;
`endif

    logic       sys_root_clk = 1'b0;
    logic       sys_root_rst = 1'b1;
    logic       ext_rstn     = 1'b1;
    logic       pll_locked   = 1'b1;
    logic       sw_rst_req   = 1'b0;
    logic       cause_clr    = 1'b0;
    logic       sys_rstn_o;
    logic [2:0] apb_rstn_o;
    logic       eth_rstn_o;
    logic       sw_rst_ack;
    logic [2:0] rst_cause;
    logic [2:0] seq_state;

    rcc_rst_seq #(.LOCK_STABLE(LS), .STAGE_GAP(SG), .FILTER_LEN(FL)) dut (
        .sys_root_clk (sys_root_clk),
        .sys_root_rst (sys_root_rst),
        .ext_rstn     (ext_rstn),
        .pll_locked   (pll_locked),
        .sw_rst_req   (sw_rst_req),
        .cause_clr    (cause_clr),
        .sys_rstn_o   (sys_rstn_o),
        .apb_rstn_o   (apb_rstn_o),
        .eth_rstn_o   (eth_rstn_o),
        .sw_rst_ack   (sw_rst_ack),
        .rst_cause    (rst_cause),
        .seq_state    (seq_state)
    );

    always #5 sys_root_clk = ~sys_root_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: state number, cycles left in the timed phase, and the
    // filtered pin level derived from a window of recent raw samples.
    int         m_state = 0;
    int         m_left  = 0;
    logic [2:0] m_cause = 3'b001;
    logic       m_ack   = 1'b0;
    logic       m_filt  = 1'b0;
    logic       hist[$];

    task automatic model_step();
        logic       f;
        logic       all_eq;
        logic [2:0] set;
        if (sys_root_rst) begin
            m_state = 0; m_left = 0; m_cause = 3'b001; m_ack = 1'b0;
            m_filt = 1'b0; hist.delete();
        end else begin
            f = m_filt;
`ifdef RST_FILTER_EN
            hist.push_back(ext_rstn);
            if (hist.size() > FL) void'(hist.pop_front());
            if (hist.size() == FL) begin
                all_eq = 1'b1;
                foreach (hist[i]) if (hist[i] != ext_rstn) all_eq = 1'b0;
                if (all_eq) m_filt = ext_rstn;
            end
`else
            m_filt = ext_rstn;
`endif
            m_ack = 1'b0;
            set   = 3'b000;
            if (!f) begin
                m_state = 0; set[0] = 1'b1;
            end else if (!pll_locked && m_state >= 2) begin
                m_state = 1; m_left = LS; set[1] = 1'b1;
            end else if (sw_rst_req && m_state == 4) begin
                m_state = 5; m_left = SG; m_ack = 1'b1; set[2] = 1'b1;
            end else begin
                case (m_state)
                    0: begin m_state = 1; m_left = LS; end
                    1: begin
                        if (!pll_locked) m_left = LS;
                        else begin
                            m_left--;
                            if (m_left == 0) begin m_state = 2; m_left = SG; end
                        end
                    end
                    2, 3, 5: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_state = (m_state == 2) ? 3 : (m_state == 3) ? 4 : 2;
                            m_left  = SG;
                        end
                    end
                    default: ;
                endcase
            end
            m_cause = (cause_clr ? 3'b000 : m_cause) | set;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [2:0] ms;
        ms = m_state[2:0];
        chk("seq_state", {5'b0, seq_state}, {5'b0, ms});
        chk("sys_rstn",  {7'b0, sys_rstn_o}, {7'b0, (m_state >= 2 && m_state <= 4)});
        chk("apb_rstn",  {5'b0, apb_rstn_o}, (m_state == 3 || m_state == 4) ? 8'h07 : 8'h00);
        chk("eth_rstn",  {7'b0, eth_rstn_o}, {7'b0, (m_state == 4)});
        chk("sw_ack",    {7'b0, sw_rst_ack}, {7'b0, m_ack});
        chk("rst_cause", {5'b0, rst_cause}, {5'b0, m_cause});
    endtask

    task automatic cyc();
        @(posedge sys_root_clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (m_state != target && n < budget) begin cyc(); n++; end
        chk(tag, {5'b0, seq_state}, target[7:0]);
    endtask

    int n;
    int burst;

    initial begin
        // Reset state
        repeat (3) cyc();
        chk("rst_state", {5'b0, seq_state}, 8'h00);
        chk("rst_cause_init", {5'b0, rst_cause}, 8'h01);
        chk("rst_outs", {5'b0, sys_rstn_o, apb_rstn_o[0], eth_rstn_o}, 8'h00);

        // Clean release: filter latency, then staged release timing
        sys_root_rst = 1'b0;
        n = 0;
        while (seq_state != 3'd1 && n < 50) begin cyc(); n++; end
        chk("lat_wait_lock", n[7:0], FILT_LAT[7:0] + 8'd1);
        n = 0;
        while (!sys_rstn_o && n < 200) begin cyc(); n++; end
        chk("lat_sys", n[7:0], LS[7:0]);
        n = 0;
        while (apb_rstn_o != 3'b111 && n < 100) begin cyc(); n++; end
        chk("lat_apb", n[7:0], SG[7:0]);
        n = 0;
        while (!eth_rstn_o && n < 100) begin cyc(); n++; end
        chk("lat_eth", n[7:0], SG[7:0]);
        chk("cause_after_release", {5'b0, rst_cause}, 8'h01);

        // Clear cause, then single-cycle lock loss in RUN
        cause_clr = 1'b1; cyc(); cause_clr = 1'b0;
        pll_locked = 1'b0; cyc(); pll_locked = 1'b1;
        chk("lockloss_state", {5'b0, seq_state}, 8'h01);
        chk("lockloss_sys", {7'b0, sys_rstn_o}, 8'h00);
        chk("lockloss_cause", {5'b0, rst_cause}, 8'h02);

        // Lock drop at count 40 restarts the stability count
        repeat (40) cyc();
        pll_locked = 1'b0; cyc(); pll_locked = 1'b1;
        n = 0;
        while (!sys_rstn_o && n < 200) begin cyc(); n++; end
        chk("relock_lat_sys", n[7:0], LS[7:0]);

        // Software reset in RUN
        run_until(4, 100, "reach_run_sw");
        sw_rst_req = 1'b1; cyc(); sw_rst_req = 1'b0;
        chk("sw_ack", {7'b0, sw_rst_ack}, 8'h01);
        chk("sw_state", {5'b0, seq_state}, 8'h05);
        n = 0;
        while (!sys_rstn_o && n < 60) begin cyc(); n++; end
        chk("sw_hold_len", n[7:0], SG[7:0]);
        run_until(4, 100, "reach_run_after_sw");

        // Software request outside RUN is ignored
        pll_locked = 1'b0; cyc(); pll_locked = 1'b1;
        cyc();
        sw_rst_req = 1'b1; cyc(); sw_rst_req = 1'b0;
        chk("sw_ignored_ack", {7'b0, sw_rst_ack}, 8'h00);
        chk("sw_ignored_state", {5'b0, seq_state}, 8'h01);

        // Short pin glitch, then a long one
        run_until(4, 200, "reach_run_glitch");
        ext_rstn = 1'b0; repeat (5) cyc(); ext_rstn = 1'b1;
        repeat (3) cyc();
        run_until(4, 300, "reach_run_long");
        ext_rstn = 1'b0; repeat (FL) cyc(); ext_rstn = 1'b1;
        cyc();
        chk("ext_long_state", {5'b0, seq_state}, 8'h00);
        chk("ext_long_cause0", {7'b0, rst_cause[0]}, 8'h01);

        // Random phase
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            sys_root_rst = ($urandom_range(0, 1999) == 0);
            pll_locked   = ($urandom_range(0, 299) != 0);
            sw_rst_req   = ($urandom_range(0, 19) == 0);
            cause_clr    = ($urandom_range(0, 49) == 0);
            if (burst > 0) begin
                ext_rstn = 1'b0; burst--;
            end else if ($urandom_range(0, 399) == 0) begin
                ext_rstn = 1'b0; burst = $urandom_range(0, 11);
            end else begin
                ext_rstn = 1'b1;
            end
            cyc();
        end

        // Reset asserted in REL_APB
        sys_root_rst = 1'b0; ext_rstn = 1'b1; pll_locked = 1'b1;
        sw_rst_req = 1'b0; cause_clr = 1'b0;
        run_until(3, 400, "reach_rel_apb");
        sys_root_rst = 1'b1; cyc(); sys_root_rst = 1'b0;
        chk("midrst_state", {5'b0, seq_state}, 8'h00);
        chk("midrst_outs", {5'b0, sys_rstn_o, apb_rstn_o[0], eth_rstn_o}, 8'h00);
        chk("midrst_cause", {5'b0, rst_cause}, 8'h01);
        repeat (5) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
